// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/ORR/EOR plus iterative MUL and UDIV/UREM,
// fronted by a valid/ready handshake so the core controller can stall on long ops.
module alu_mc #(
    parameter int WIDTH      = 32,
    parameter bit ENABLE_DIV = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic             illegal
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [1:0] {K_MUL, K_DIV, K_REM} kind_t;

    state_t           state, state_nx;
    kind_t            kind;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, px, py;

    // ---------------- op decode ----------------
    logic is_mul, is_div, is_long;
    always_comb begin
        is_mul  = (ALUControl == 4'b0101);
        is_div  = ENABLE_DIV && (ALUControl == 4'b0110 || ALUControl == 4'b0111);
        // divide-by-zero resolves in one cycle, so it never enters CALC
        is_long = is_mul || (is_div && (b != '0));
    end

    // ---------------- single-cycle datapath ----------------
    logic             sub, s_c, s_v, s_ill;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] s_res;
    always_comb begin
        sub   = (ALUControl == 4'b0001);
        sum   = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{WIDTH{1'b0}}, sub};
        s_res = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        s_ill = 1'b0;
        case (ALUControl)
            4'b0000, 4'b0001: begin
                s_res = sum[WIDTH-1:0];
                s_c   = sum[WIDTH];
                s_v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ sum[WIDTH-1]);
            end
            4'b0010: s_res = a & b;
            4'b0011: s_res = a | b;
            4'b0100: s_res = a ^ b;
            4'b0101: s_res = '0;
            4'b0110: begin
                if (is_div) begin
                    s_res = '1;
                    s_v   = 1'b1;
                end else begin
                    s_ill = 1'b1;
                end
            end
            4'b0111: begin
                if (is_div) begin
                    s_res = a;
                    s_v   = 1'b1;
                end else begin
                    s_ill = 1'b1;
                end
            end
            default: s_ill = 1'b1;
        endcase
    end

    // ---------------- one iteration of shift-add / restoring divide ----------------
    // MUL: acc = partial product, px = multiplier (shifts right), py = multiplicand (shifts left)
    // DIV: acc = partial remainder, px = dividend shifting out / quotient shifting in, py = divisor
    logic [WIDTH-1:0] acc_nx, px_nx, py_nx, long_res;
    logic [WIDTH:0]   rem_sh, diff;
    always_comb begin
        acc_nx = acc;
        px_nx  = px;
        py_nx  = py;
        rem_sh = '0;
        diff   = '0;
        if (kind == K_MUL) begin
            acc_nx = px[0] ? acc + py : acc;
            px_nx  = px >> 1;
            py_nx  = py << 1;
        end else begin
            rem_sh = {acc, px[WIDTH-1]};
            diff   = rem_sh - {1'b0, py};
            // remainder stays below the divisor, so diff's top bit is a pure borrow flag
            if (!diff[WIDTH]) begin
                acc_nx = diff[WIDTH-1:0];
                px_nx  = {px[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = rem_sh[WIDTH-1:0];
                px_nx  = {px[WIDTH-2:0], 1'b0};
            end
        end
        long_res = (kind == K_DIV) ? px_nx : acc_nx;
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = is_long ? CALC : DONE;
            CALC:    if (cnt == LAST) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            kind     <= K_MUL;
            cnt      <= '0;
            acc      <= '0;
            px       <= '0;
            py       <= '0;
            Result   <= '0;
            ALUFlags <= '0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_long) begin
                            cnt  <= '0;
                            acc  <= '0;
                            px   <= is_mul ? b : a;
                            py   <= is_mul ? a : b;
                            kind <= is_mul ? K_MUL : (ALUControl[0] ? K_REM : K_DIV);
                        end else begin
                            Result   <= s_res;
                            ALUFlags <= {s_res[WIDTH-1], (s_res == '0), s_c, s_v};
                            illegal  <= s_ill;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nx;
                    px  <= px_nx;
                    py  <= py_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        Result   <= long_res;
                        ALUFlags <= {long_res[WIDTH-1], (long_res == '0), 2'b00};
                        illegal  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: three instances (32-bit, 8-bit, 32-bit without divide) driven by
// directed and random ops, checked against an arithmetic reference model.
module tb_alu_mc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  iv = '0;
    logic [2:0]  ordy = '0;
    logic [3:0]  ctl [3];
    logic [31:0] av [3];
    logic [31:0] bv [3];

    logic        ir0, ir1, ir2, ov0, ov1, ov2, il0, il1, il2;
    logic [31:0] r0, r2;
    logic [7:0]  r1;
    logic [3:0]  f0, f1, f2;

    int n_chk = 0;
    int n_fail = 0;

    alu_mc #(.WIDTH(32), .ENABLE_DIV(1'b1)) u0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir0), .a(av[0]), .b(bv[0]),
        .ALUControl(ctl[0]), .out_valid(ov0), .out_ready(ordy[0]), .Result(r0),
        .ALUFlags(f0), .illegal(il0));
    alu_mc #(.WIDTH(8), .ENABLE_DIV(1'b1)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir1), .a(av[1][7:0]),
        .b(bv[1][7:0]), .ALUControl(ctl[1]), .out_valid(ov1), .out_ready(ordy[1]),
        .Result(r1), .ALUFlags(f1), .illegal(il1));
    alu_mc #(.WIDTH(32), .ENABLE_DIV(1'b0)) u2 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir2), .a(av[2]), .b(bv[2]),
        .ALUControl(ctl[2]), .out_valid(ov2), .out_ready(ordy[2]), .Result(r2),
        .ALUFlags(f2), .illegal(il2));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int i, output logic ir, output logic ov, output logic il,
                          output logic [31:0] r, output logic [3:0] f);
        case (i)
            0:       begin ir = ir0; ov = ov0; il = il0; r = r0;           f = f0; end
            1:       begin ir = ir1; ov = ov1; il = il1; r = {24'd0, r1}; f = f1; end
            default: begin ir = ir2; ov = ov2; il = il2; r = r2;           f = f2; end
        endcase
    endtask

    // Reference: what the op means arithmetically at width w, and how long it should take.
    function automatic void model(input int w, input bit den, input logic [3:0] op,
                                  input logic [31:0] x_in, input logic [31:0] y_in,
                                  output logic [31:0] r, output logic [3:0] f,
                                  output logic ill, output int lat);
        longint unsigned m, x, y, s, rr;
        bit c, v, sx, sy, sr;
        m = (64'd1 << w) - 1;
        x = {32'd0, x_in} & m;
        y = {32'd0, y_in} & m;
        rr = 0; c = 0; v = 0; ill = 0; lat = 1;
        sx = x[w-1];
        sy = y[w-1];
        case (op)
            4'd0: begin
                s = x + y; rr = s & m; c = s[w]; sr = rr[w-1];
                v = (sx == sy) && (sr != sx);
            end
            4'd1: begin
                s = x + ((~y) & m) + 1; rr = s & m; c = s[w]; sr = rr[w-1];
                v = (sx != sy) && (sr != sx);
            end
            4'd2: rr = x & y;
            4'd3: rr = x | y;
            4'd4: rr = x ^ y;
            4'd5: begin rr = (x * y) & m; lat = w + 1; end
            4'd6, 4'd7: begin
                if (!den) ill = 1;
                else if (y == 0) begin rr = (op == 4'd6) ? m : x; v = 1; end
                else begin rr = (op == 4'd6) ? x / y : x % y; lat = w + 1; end
            end
            default: ill = 1;
        endcase
        r = rr[31:0];
        f = {rr[w-1], (rr == 0), c, v};
    endfunction

    // Issue one op on instance i, hold the result under backpressure for 'hold' cycles.
    task automatic run_op(input int i, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input int hold, input string tag);
        logic [31:0] er, r;
        logic [3:0]  ef, f;
        logic        eil, ir, ov, il;
        int          lat, cyc;
        bit          busy_bad, hold_bad;
        model((i == 1) ? 8 : 32, (i != 2), op, x, y, er, ef, eil, lat);
        sample(i, ir, ov, il, r, f);
        check({tag, "/in_ready_idle"}, ir, 1);
        iv[i] = 1'b1; ctl[i] = op; av[i] = x; bv[i] = y;
        @(posedge clk); #1;
        iv[i] = 1'b0; ctl[i] = 4'($urandom); av[i] = $urandom; bv[i] = $urandom;
        cyc = 1; busy_bad = 0; hold_bad = 0;
        sample(i, ir, ov, il, r, f);
        while (!ov && cyc < 200) begin
            if (ir) busy_bad = 1;
            @(posedge clk); #1;
            cyc++;
            sample(i, ir, ov, il, r, f);
        end
        if (ir) busy_bad = 1;
        check({tag, "/latency"}, cyc, lat);
        for (int k = 0; k < hold; k++) begin
            iv[i] = 1'($urandom_range(0, 1));
            ctl[i] = 4'($urandom);
            @(posedge clk); #1;
            sample(i, ir, ov, il, r, f);
            if (!ov || ir || r !== er) hold_bad = 1;
        end
        iv[i] = 1'b0;
        check({tag, "/busy_in_ready_low"}, busy_bad, 0);
        check({tag, "/held"}, hold_bad, 0);
        check({tag, "/result"}, r, er);
        check({tag, "/flags"}, f, ef);
        check({tag, "/illegal"}, il, eil);
        ordy[i] = 1'b1;
        @(posedge clk); #1;
        ordy[i] = 1'b0;
        sample(i, ir, ov, il, r, f);
        check({tag, "/out_valid_drop"}, ov, 0);
        check({tag, "/in_ready_back"}, ir, 1);
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        logic        ir, ov, il;
        logic [3:0]  op;
        logic [31:0] x, y;
        int          inst;
        for (int i = 0; i < 3; i++) begin ctl[i] = '0; av[i] = '0; bv[i] = '0; end

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample(i, ir, ov, il, r, f);
            check("reset/out_valid", ov, 0);
            check("reset/result", r, 0);
            check("reset/flags", f, 0);
            check("reset/in_ready", ir, 1);
            check("reset/illegal", il, 0);
        end

        run_op(0, 4'd0, 32'h7FFF_FFFF, 32'd1, 0, "add_ovf");
        check("add_ovf/const_result", r0, 32'h8000_0000);
        check("add_ovf/const_flags", f0, 4'b1001);
        run_op(0, 4'd1, 32'd5, 32'd5, 0, "sub_eq");
        check("sub_eq/const_flags", f0, 4'b0110);
        ordy[0] = 1'b1;
        run_op(0, 4'd5, 32'h0001_0001, 32'h0001_0001, 0, "mul_33");
        check("mul_33/const_result", r0, 32'h0002_0001);
        run_op(1, 4'd6, 32'd200, 32'd7, 0, "udiv8");
        check("udiv8/const_result", r1, 8'd28);
        run_op(1, 4'd7, 32'd200, 32'd7, 0, "urem8");
        run_op(1, 4'd6, 32'd9, 32'd0, 0, "udiv8_zero");
        check("udiv8_zero/const_flags", f1, 4'b1001);
        run_op(1, 4'd7, 32'd9, 32'd0, 0, "urem8_zero");
        run_op(0, 4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 5, "eor_bp");
        check("eor_bp/const_result", r0, 32'h0F0F_F0F0);
        run_op(0, 4'd1, 32'd0, 32'd1, 0, "sub_borrow");
        run_op(0, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "add_carry");
        run_op(0, 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_max");
        run_op(0, 4'd6, 32'hDEAD_BEEF, 32'd1, 0, "udiv_one");
        run_op(0, 4'd7, 32'd3, 32'hFFFF_FFF0, 0, "urem_small");
        run_op(2, 4'd6, 32'd100, 32'd3, 0, "nodiv_0110");
        run_op(2, 4'd7, 32'd100, 32'd3, 0, "nodiv_0111");
        run_op(2, 4'd15, 32'd1, 32'd2, 0, "nodiv_1111");
        run_op(0, 4'd9, 32'd1, 32'd2, 0, "illegal_1001");

        // reset in the middle of a 32-bit divide, just before iteration 10
        iv[0] = 1'b1; ctl[0] = 4'd6; av[0] = 32'hFFFF_FF00; bv[0] = 32'd3;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("rst_mid/not_done", ov0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid/out_valid", ov0, 0);
        check("rst_mid/result", r0, 0);
        check("rst_mid/flags", f0, 0);
        check("rst_mid/in_ready", ir0, 1);
        run_op(0, 4'd0, 32'd1, 32'd2, 0, "rst_mid_add");
        check("rst_mid_add/const_result", r0, 32'd3);

        for (int n = 0; n < 60; n++) begin
            inst = $urandom_range(0, 2);
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 7));
            x = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
            run_op(inst, op, x, y, $urandom_range(0, 3), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
